// File: rtl/cbus_mem_responder_pkg.sv
// rtl/cbus_mem_responder_pkg.sv - cache bus types and memory responder state encoding
package cbus_mem_responder_pkg;

    localparam int CBUS_WORD_BYTES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} cmr_state_t;

    typedef enum logic {BURST_FIXED = 1'b0, BURST_INCR = 1'b1} cbus_burst_t;

    typedef struct packed {
        logic                         valid;
        logic                         is_write;
        logic [2:0]                   size;
        logic [31:0]                  addr;
        logic [CBUS_WORD_BYTES-1:0]   strobe;
        logic [31:0]                  data;
        logic [3:0]                   len;
        cbus_burst_t                  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_ram.sv
// rtl/cbus_ram.sv - word RAM with async read and byte-enable sync write, no reset
module cbus_ram
    import cbus_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
    output logic [31:0]                  rd_data,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
    input  logic [CBUS_WORD_BYTES-1:0]   wr_strb,
    input  logic [31:0]                  wr_data
);

    logic [31:0] mem [MEM_WORDS];

    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < CBUS_WORD_BYTES; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cbus_mem_responder.sv
// rtl/cbus_mem_responder.sv - cache bus responder serving bursts from an internal RAM
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    cmr_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       beat;
    logic [3:0]       lat;
    logic [3:0]       len_q;
    logic             is_write_q;
    cbus_burst_t      burst_q;
    logic             ready;
    logic             last;
    logic [31:0]      rd_data;

    // Only the word index of the address and the per-beat payload matter here.
    logic unused_req;
    assign unused_req = ^{creq.size, creq.addr[31:IDX_W+2], creq.addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            beat       <= '0;
            lat        <= '0;
            len_q      <= '0;
            is_write_q <= 1'b0;
            burst_q    <= BURST_FIXED;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (creq.valid) begin
                        is_write_q <= creq.is_write;
                        len_q      <= creq.len;
                        burst_q    <= creq.burst;
                        idx        <= creq.addr[IDX_W+1:2];
                        beat       <= '0;
                        lat        <= LAT_INIT;
                    end
                end
                WAIT: lat <= lat - 4'd1;
                BURST: begin
                    if (ready) begin
                        beat <= beat + 4'd1;
                        if (burst_q == BURST_INCR) begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Dropping valid mid-transaction is a protocol violation: abandon the burst.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (creq.valid) begin
                    state_nxt = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    state_nxt = IDLE;
                end else if (lat == 4'd1) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == BURST) && creq.valid;
    assign last  = ready && (beat == len_q);

    assign cresp.ready = ready;
    assign cresp.last  = last;
    assign cresp.data  = (ready && !is_write_q) ? rd_data : 32'h0;

    cbus_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .rd_idx  (idx),
        .rd_data (rd_data),
        .we      (ready && is_write_q),
        .wr_idx  (idx),
        .wr_strb (creq.strobe),
        .wr_data (creq.data)
    );

endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb/tb_cbus_mem_responder.sv - directed self-checking bench for cbus_mem_responder
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    localparam int LATENCY   = 2;
    localparam int MEM_WORDS = 4096;

    logic       clk;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wdat [16];
    logic [31:0] expd [16];

    cbus_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq),
        .cresp  (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                        input cbus_burst_t b, input logic [3:0] strb, input logic keep,
                        input string tag);
        int  beat;
        int  cyc;
        bit  done;
        @(posedge clk); #1;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = 3'd2;
        creq.addr     = addr;
        creq.len      = len;
        creq.burst    = b;
        creq.strobe   = strb;
        creq.data     = wdat[0];
        beat = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (cresp.ready) begin
                check($sformatf("%s cyc b%0d", tag, beat), 32'(cyc), 32'(LATENCY + 1 + beat));
                check($sformatf("%s data b%0d", tag, beat), cresp.data, wr ? 32'h0 : expd[beat]);
                check($sformatf("%s last b%0d", tag, beat), 32'(cresp.last), 32'(beat == int'(len)));
                if (beat == int'(len)) done = 1'b1;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
            if (!done) creq.data = wdat[beat];
        end
        if (!done) check({tag, " beats"}, 32'(beat), 32'(len) + 32'd1);
        if (!keep) creq.valid = 1'b0;
        @(negedge clk);
        check({tag, " done ready"}, 32'(cresp.ready), 32'h0);
    endtask

    initial begin
        int cyc;
        int beat;
        resetn = 1'b0;
        creq   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(cresp.ready), 32'h0);
        check("rst last", 32'(cresp.last), 32'h0);
        check("rst data", cresp.data, 32'h0);
        resetn = 1'b1;

        // Incrementing read of four preloaded words
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'hA0 + 32'(i);
            expd[i] = 32'hA0 + 32'(i);
        end
        xfer(1'b1, 32'h100, 4'd3, BURST_INCR, 4'hF, 1'b0, "pre1");
        xfer(1'b0, 32'h100, 4'd3, BURST_INCR, 4'hF, 1'b0, "rd4");

        // Partial-strobe write
        wdat[0] = 32'h11223344;
        xfer(1'b1, 32'h40, 4'd0, BURST_INCR, 4'hF, 1'b0, "pre2");
        wdat[0] = 32'hAABBCCDD;
        xfer(1'b1, 32'h40, 4'd0, BURST_INCR, 4'b0011, 1'b0, "wstrb");
        expd[0] = 32'h1122CCDD;
        xfer(1'b0, 32'h40, 4'd0, BURST_INCR, 4'hF, 1'b0, "rstrb");

        // FIXED read; ram[3] differs so any idx advance would show
        wdat[0] = 32'h5A;
        wdat[1] = 32'h77;
        xfer(1'b1, 32'h8, 4'd1, BURST_INCR, 4'hF, 1'b0, "pre3");
        for (int i = 0; i < 4; i++) expd[i] = 32'h5A;
        xfer(1'b0, 32'h8, 4'd3, BURST_FIXED, 4'hF, 1'b0, "fixed");

        // Index wrap at the top of the RAM
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'hC000_0000 + 32'(i);
            expd[i] = 32'hC000_0000 + 32'(i);
        end
        xfer(1'b1, 32'((MEM_WORDS - 2) * 4), 4'd3, BURST_INCR, 4'hF, 1'b0, "pre4");
        xfer(1'b0, 32'((MEM_WORDS - 2) * 4), 4'd3, BURST_INCR, 4'hF, 1'b0, "wrap");
        expd[0] = 32'hC000_0002;
        xfer(1'b0, 32'h0, 4'd0, BURST_INCR, 4'hF, 1'b0, "wrap0");

        // Reset in the middle of a write burst
        for (int i = 0; i < 4; i++) wdat[i] = 32'h0DD0_0000 + 32'(i);
        xfer(1'b1, 32'h200, 4'd3, BURST_INCR, 4'hF, 1'b0, "pre5");
        for (int i = 0; i < 4; i++) wdat[i] = 32'h0E00_0000 + 32'(i);
        @(posedge clk); #1;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = 32'h200;
        creq.len      = 4'd3;
        creq.burst    = BURST_INCR;
        creq.strobe   = 4'hF;
        creq.data     = wdat[0];
        beat = 0;
        cyc  = 0;
        while (beat < 2 && cyc < 20) begin
            @(negedge clk);
            if (cresp.ready) beat++;
            @(posedge clk); #1;
            cyc++;
            creq.data = wdat[beat];
        end
        check("rst mid beats", 32'(beat), 32'd2);
        resetn = 1'b0;
        #1;
        check("rst mid ready", 32'(cresp.ready), 32'h0);
        check("rst mid state", 32'(dut.state), 32'(IDLE));
        creq.valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        expd[0] = 32'h0E00_0000;
        expd[1] = 32'h0E00_0001;
        expd[2] = 32'h0DD0_0002;
        expd[3] = 32'h0DD0_0003;
        xfer(1'b0, 32'h200, 4'd3, BURST_INCR, 4'hF, 1'b0, "rst rd");

        // LEN16 read, then a write held back-to-back behind it
        for (int i = 0; i < 16; i++) begin
            wdat[i] = 32'h1000 + 32'(i);
            expd[i] = 32'h1000 + 32'(i);
        end
        xfer(1'b1, 32'h400, 4'd15, BURST_INCR, 4'hF, 1'b0, "pre6");
        xfer(1'b0, 32'h400, 4'd15, BURST_INCR, 4'hF, 1'b1, "ic16");
        wdat[0] = 32'hCAFEF00D;
        xfer(1'b1, 32'h500, 4'd0, BURST_INCR, 4'hF, 1'b0, "dcw");
        expd[0] = 32'hCAFEF00D;
        xfer(1'b0, 32'h500, 4'd0, BURST_INCR, 4'hF, 1'b0, "dcr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
